// File: rtl/ex_mem_pipe_reg_pkg.sv
// Shared definitions for the EX->MEM pipeline register: default widths,
// ALU op encodings and the op-code legality screen.
package ex_mem_pipe_reg_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;
  localparam int ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001
  } alu_op_e;

  function automatic logic alu_op_legal(input logic [ALU_CTRL_W-1:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL: legal = 1'b1;
      default:                                            legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// One payload register with a valid bit; used as both the main and the skid
// slot of the EX->MEM boundary.
module ex_mem_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // NOTE: the payload is reset too, so a reset mid-stall leaves every MEM
  // output at 0 rather than showing stale data behind a low valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with a 2-entry skid, branch resolution and
// illegal ALU op screening. Define EX_MEM_FWD_EN to add the forwarding ports.
module ex_mem_pipe_reg
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
  input  logic [XLEN-1:0]       ex_alu_result,
  input  logic                  ex_zero,
  input  logic [XLEN-1:0]       ex_store_data,
  input  logic [XLEN-1:0]       ex_branch_target,
  input  logic [REG_AW-1:0]     ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_branch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       mem_alu_result,
  output logic [XLEN-1:0]       mem_store_data,
  output logic [XLEN-1:0]       mem_branch_target,
  output logic [REG_AW-1:0]     mem_rd,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_pc_src,
  output logic                  mem_illegal
`ifdef EX_MEM_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_AW-1:0]     fwd_rd,
  output logic [XLEN-1:0]       fwd_data
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   store_data;
    logic [XLEN-1:0]   branch_target;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              pc_src;
    logic              illegal;
  } payload_t;

  localparam int PW = $bits(payload_t);

  payload_t in_pl, main_pl, skid_pl, main_d;
  logic     main_valid, skid_valid;
  logic     accept, drain;
  logic     main_load, main_clr, skid_load, skid_clr;
  logic     legal;

  // Controls are resolved and screened on entry, so both slots only ever
  // hold MEM-ready side effects.
  always_comb begin
    legal                = alu_op_legal(ex_alu_ctrl);
    in_pl                = '0;
    in_pl.alu_result     = ex_alu_result;
    in_pl.store_data     = ex_store_data;
    in_pl.branch_target  = ex_branch_target;
    in_pl.rd             = ex_rd;
    in_pl.reg_write      = ex_reg_write & legal;
    in_pl.mem_read       = ex_mem_read  & legal;
    in_pl.mem_write      = ex_mem_write & legal;
    in_pl.pc_src         = ex_branch & ex_zero & legal;
    in_pl.illegal        = ~legal;
  end

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid & out_ready;

  // The skid always has priority into main so ordering is preserved; accept
  // cannot coincide with a full skid because in_ready is low then.
  always_comb begin
    main_load = (~main_valid | drain) & (skid_valid | accept);
    main_clr  = flush | (drain & ~main_load);
    main_d    = skid_valid ? skid_pl : in_pl;
    skid_load = accept & main_valid & ~drain;
    skid_clr  = flush | (skid_valid & drain);
  end

  // NOTE: clr outranks load inside the slot, which is what lets flush drop a
  // same-cycle incoming entry without extra gating here.
  ex_mem_slot #(.W(PW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clr   (main_clr),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_pl)
  );

  ex_mem_slot #(.W(PW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clr   (skid_clr),
    .d     (in_pl),
    .valid (skid_valid),
    .q     (skid_pl)
  );

  assign out_valid         = main_valid;
  assign mem_alu_result    = main_pl.alu_result;
  assign mem_store_data    = main_pl.store_data;
  assign mem_branch_target = main_pl.branch_target;
  assign mem_rd            = main_pl.rd;
  assign mem_reg_write     = main_pl.reg_write & main_valid;
  assign mem_mem_read      = main_pl.mem_read  & main_valid;
  assign mem_mem_write     = main_pl.mem_write & main_valid;
  assign mem_pc_src        = main_pl.pc_src    & main_valid;
  assign mem_illegal       = main_pl.illegal   & main_valid;

`ifdef EX_MEM_FWD_EN
  assign fwd_valid = mem_reg_write & (main_pl.rd != '0);
  assign fwd_rd    = main_pl.rd;
  assign fwd_data  = main_pl.alu_result;
`endif

endmodule
